fetch_queue: RTL and testbench



---
 rtl/fetch_queue.sv | 139 +++++++++++++
 tb/tb_fetch_queue.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction fetch stage with a small prefetch queue. Owns the
//            fetch PC, drives the instruction-memory address and buffers up
//            to DEPTH fetched {pc, instruction, pc+4} entries so that decode
//            can stall without throttling fetch. A redirect from execute
//            flushes the queue and reloads the fetch PC.
// Ports    : clk_i        - clock, all state changes on rising edge
//            rst_ni       - asynchronous active-low reset
//            A_o          - instruction-memory address (current fetch PC)
//            RD_i         - instruction-memory read data (combinational of A_o)
//            redirect_i   - taken branch/jump from execute
//            redirectPc_i - redirect target (low two bits ignored)
//            stall_i      - decode not accepting the head entry
//            validD_o     - head entry valid
//            InstrD_o     - head instruction
//            pcD_o        - head PC
//            pcPlus4D_o   - head PC + 4
//            count_o      - current queue occupancy
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int unsigned          PC_WIDTH          = 32,
  parameter int unsigned          INSTRUCTION_WIDTH = 32,
  parameter int unsigned          DEPTH             = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_PC          = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  output logic [PC_WIDTH-1:0]           A_o,
  input  logic [INSTRUCTION_WIDTH-1:0]  RD_i,
  input  logic                          redirect_i,
  input  logic [PC_WIDTH-1:0]           redirectPc_i,
  input  logic                          stall_i,
  output logic                          validD_o,
  output logic [INSTRUCTION_WIDTH-1:0]  InstrD_o,
  output logic [PC_WIDTH-1:0]           pcD_o,
  output logic [PC_WIDTH-1:0]           pcPlus4D_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  localparam logic [CNT_W-1:0]    FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0]    PTR_ONE    = PTR_W'(1);
  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PC_WIDTH-1:0]          pc_f;
  logic [PTR_W-1:0]             rd_ptr;
  logic [PTR_W-1:0]             wr_ptr;
  logic [CNT_W-1:0]             count;

  logic [PC_WIDTH-1:0]          pc_mem    [DEPTH];
  logic [INSTRUCTION_WIDTH-1:0] instr_mem [DEPTH];
  logic [PC_WIDTH-1:0]          pc4_mem   [DEPTH];

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  logic                 not_empty;
  logic                 not_full;
  logic                 pop;
  logic                 push;
  logic [PC_WIDTH-1:0]  pc_f_plus4;
  logic [PC_WIDTH-1:0]  redirect_aligned;

  assign not_empty        = (count != '0);
  assign not_full         = (count < FULL_COUNT);
  // A head presented during a redirect cycle is discarded by the flush, so
  // pop is only meaningful when no redirect is present; the pointer update
  // below gives redirect priority anyway.
  assign pop              = not_empty & ~stall_i;
  // A full queue may still accept when its head leaves in the same cycle.
  assign push             = ~redirect_i & (not_full | pop);
  // Wraps modulo 2^PC_WIDTH naturally by truncation.
  assign pc_f_plus4       = pc_f + PC_STEP;
  assign redirect_aligned = {redirectPc_i[PC_WIDTH-1:2], 2'b00};

  // --------------------------------------------------------------------------
  // Fetch PC, pointers and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_f   <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_i) begin
      pc_f   <= redirect_aligned;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_f   <= pc_f_plus4;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Entry storage. Contents are qualified by count, so no reset is needed;
  // push is already gated by redirect.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr]    <= pc_f;
      instr_mem[wr_ptr] <= RD_i;
      pc4_mem[wr_ptr]   <= pc_f_plus4;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: taken only from registered state, never from redirect/stall.
  // When empty the head fields still show the slot at the read pointer.
  // --------------------------------------------------------------------------
  assign A_o        = pc_f;
  assign validD_o   = not_empty;
  assign count_o    = count;
  assign pcD_o      = pc_mem[rd_ptr];
  assign InstrD_o   = instr_mem[rd_ptr];
  assign pcPlus4D_o = pc4_mem[rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Self-checking bench for fetch_queue. A reference model keeps the
//            expected queue contents as a list of PCs; a monitor compares the
//            DUT head/count/address against it on every falling edge. Directed
//            sequences are followed by randomized stall/redirect traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  localparam int unsigned PCW   = 32;
  localparam int unsigned IW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] A_o;
  logic [31:0] RD_i;
  logic        redirect_i = 1'b0;
  logic [31:0] redirectPc_i = '0;
  logic        stall_i = 1'b0;
  logic        validD_o;
  logic [31:0] InstrD_o;
  logic [31:0] pcD_o;
  logic [31:0] pcPlus4D_o;
  logic [2:0]  count_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  // Instruction memory: word k holds k.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  assign RD_i = imem(A_o);

  fetch_queue #(
    .PC_WIDTH(PCW), .INSTRUCTION_WIDTH(IW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .A_o(A_o), .RD_i(RD_i),
    .redirect_i(redirect_i), .redirectPc_i(redirectPc_i), .stall_i(stall_i),
    .validD_o(validD_o), .InstrD_o(InstrD_o), .pcD_o(pcD_o),
    .pcPlus4D_o(pcPlus4D_o), .count_o(count_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: the queue is a list of fetched PCs, plus the fetch PC.
  // --------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  bit          m_pop;
  bit          m_room;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_q.delete();
      m_pc = RESET_PC;
    end else if (redirect_i) begin
      exp_q.delete();
      m_pc = redirectPc_i & 32'hFFFF_FFFC;
    end else begin
      m_pop  = (exp_q.size() > 0) && !stall_i;
      m_room = (exp_q.size() < DEPTH) || m_pop;
      if (m_pop) void'(exp_q.pop_front());
      if (m_room) begin
        exp_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // Monitor: compare DUT against the model away from the active edge.
  always @(negedge clk_i) begin
    check("count_o", {29'd0, count_o}, exp_q.size());
    check("validD_o", {31'd0, validD_o}, {31'd0, exp_q.size() > 0});
    check("A_o", A_o, m_pc);
    if (validD_o && exp_q.size() > 0) begin
      check("pcD_o", pcD_o, exp_q[0]);
      check("InstrD_o", InstrD_o, imem(exp_q[0]));
      check("pcPlus4D_o", pcPlus4D_o, exp_q[0] + 32'd4);
    end
  end

  // Apply inputs for one cycle; returns 1 time unit after the rising edge.
  task automatic cyc(input bit s, input bit r, input logic [31:0] t);
    stall_i      = s;
    redirect_i   = r;
    redirectPc_i = t;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [31:0] tgt;
    #23 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    // First edge after reset release pushes RESET_PC.
    check("first_valid", {31'd0, validD_o}, 32'd1);
    check("first_pc", pcD_o, RESET_PC);

    // Fill to full with stall held.
    cyc(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 32'h0);
      check("fill_count", {29'd0, count_o}, (i < 4) ? i + 1 : 4);
    end
    check("fill_A", A_o, 32'd16);
    check("fill_head", pcD_o, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 32'h0);
      check("release_head", pcD_o, 32'(4 * (i + 1)));
    end

    // Redirect while full and stalled.
    cyc(1'b1, 1'b1, 32'h0000_0103);
    check("redir_count", {29'd0, count_o}, 32'd0);
    check("redir_valid", {31'd0, validD_o}, 32'd0);
    check("redir_A", A_o, 32'h100);
    cyc(1'b1, 1'b0, 32'h0);
    check("redir_valid2", {31'd0, validD_o}, 32'd1);
    check("redir_pc", pcD_o, 32'h100);

    // Redirect together with a would-be pop.
    cyc(1'b0, 1'b1, 32'h200);
    check("redpop_valid", {31'd0, validD_o}, 32'd0);
    cyc(1'b0, 1'b0, 32'h0);
    check("redpop_pc", pcD_o, 32'h200);

    // PC wrap.
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 32'h0);
    check("wrap_pc", pcD_o, 32'hFFFF_FFFC);
    check("wrap_pc4", pcPlus4D_o, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    check("wrap_next", pcD_o, 32'h0);

    // Asynchronous reset with three entries queued.
    cyc(1'b0, 1'b1, 32'h40);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0);
    check("pre_reset_count", {29'd0, count_o}, 32'd3);
    #2 rst_ni = 1'b0;
    #1;
    check("areset_valid", {31'd0, validD_o}, 32'd0);
    check("areset_count", {29'd0, count_o}, 32'd0);
    check("areset_A", A_o, RESET_PC);
    stall_i = 1'b0;
    #5 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("refill_valid", {31'd0, validD_o}, 32'd1);
    check("refill_pc", pcD_o, RESET_PC);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 + ($urandom % 16);
      else                           tgt = $urandom;
      cyc(bit'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0), tgt);
    end
    @(negedge clk_i);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
